// File: rtl/pc_pkg.sv
// Shared defaults and the next-PC source encoding for the program counter unit.
package pc_pkg;

  localparam int          DEF_ADDR_W    = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;
  localparam int          DEF_INC       = 4;
  localparam int          DEF_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    SRC_RST,
    SRC_EXC,
    SRC_HOLD,
    SRC_REDIR,
    SRC_PEND,
    SRC_RET,
    SRC_SEQ
  } pc_src_e;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch-control bundle between the pipeline (master) and the PC unit (slave).
interface pc_unit_if
  import pc_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH
);

  logic                           stall_i;
  logic                           keep_i;
  logic                           redir_valid_i;
  logic [ADDR_W-1:0]              redir_pc_i;
  logic                           exc_i;
  logic                           call_i;
  logic                           ret_i;
  logic [ADDR_W-1:0]              pc_o;
  logic                           pend_o;
  logic                           misalign_o;
  logic                           ras_underflow_o;
  logic [$clog2(RAS_DEPTH):0]     ras_cnt_o;

  modport master (
    output stall_i, keep_i, redir_valid_i, redir_pc_i, exc_i, call_i, ret_i,
    input  pc_o, pend_o, misalign_o, ras_underflow_o, ras_cnt_o
  );

  modport slave (
    input  stall_i, keep_i, redir_valid_i, redir_pc_i, exc_i, call_i, ret_i,
    output pc_o, pend_o, misalign_o, ras_underflow_o, ras_cnt_o
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int W     = DEF_ADDR_W,
  parameter int DEPTH = DEF_RAS_DEPTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [W-1:0]              push_data,
  output logic [W-1:0]              top,
  output logic [$clog2(DEPTH):0]    cnt,
  output logic                      empty,
  output logic                      full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_idx;
  logic             wr_en;
  logic [W-1:0]     mem [DEPTH];

  assign top_idx = ptr_reg - PTR_W'(1);
  assign empty   = (cnt_reg == '0);
  assign full    = (cnt_reg == CNT_W'(DEPTH));
  assign cnt     = cnt_reg;
  assign top     = mem[top_idx];

  always_comb begin
    ptr_next = ptr_reg;
    cnt_next = cnt_reg;
    wr_idx   = ptr_reg;
    wr_en    = 1'b0;
    if (flush) begin
      ptr_next = '0;
      cnt_next = '0;
    end else if (push && pop && !empty) begin
      // call+return in one fetch: replace the top in place
      wr_idx = top_idx;
      wr_en  = 1'b1;
    end else if (push) begin
      wr_en    = 1'b1;
      ptr_next = ptr_reg + PTR_W'(1);
      cnt_next = full ? cnt_reg : cnt_reg + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_next = top_idx;
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      ptr_reg <= '0;
      cnt_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
      cnt_reg <= cnt_next;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [W-1:0] entry_reg;
    always_ff @(negedge clk_i) begin
      if (wr_en && (wr_idx == PTR_W'(gi))) begin
        entry_reg <= push_data;
      end
    end
    assign mem[gi] = entry_reg;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with buffered redirects, exception vectoring and a return-address stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
  parameter int                INC       = DEF_INC,
  parameter int                RAS_DEPTH = DEF_RAS_DEPTH
) (
  input logic      clk_i,
  input logic      rst_i,
  pc_unit_if.slave bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);

  pc_src_e           src;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              pend_reg, pend_next;
  logic [ADDR_W-1:0] pend_tgt_reg, pend_tgt_next;
  logic              misalign_reg, misalign_next;
  logic              underflow_reg, underflow_next;
  logic [ADDR_W-1:0] link_pc;
  logic [ADDR_W-1:0] redir_tgt;
  logic              redir_bad;
  logic              ras_push, ras_pop, ras_flush;
  logic [ADDR_W-1:0] ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_cnt;
  logic              ras_empty, ras_full;

  assign link_pc   = pc_reg + ADDR_W'(INC);
  assign redir_tgt = bus.redir_valid_i ? bus.redir_pc_i : pend_tgt_reg;
  assign redir_bad = (redir_tgt & ALIGN_MASK) != '0;

  always_comb begin
    if (rst_i)                            src = SRC_RST;
    else if (bus.exc_i)                   src = SRC_EXC;
    else if (bus.stall_i || bus.keep_i)   src = SRC_HOLD;
    else if (bus.redir_valid_i)           src = SRC_REDIR;
    else if (pend_reg)                    src = SRC_PEND;
    else if (bus.ret_i)                   src = SRC_RET;
    else                                  src = SRC_SEQ;
  end

  always_comb begin
    pc_next        = pc_reg;
    pend_next      = pend_reg;
    pend_tgt_next  = pend_tgt_reg;
    misalign_next  = 1'b0;
    underflow_next = 1'b0;
    ras_pop        = 1'b0;
    ras_flush      = 1'b0;
    case (src)
      SRC_RST: begin
        pc_next       = RESET_VEC;
        pend_next     = 1'b0;
        pend_tgt_next = '0;
        ras_flush     = 1'b1;
      end
      SRC_EXC: begin
        pc_next   = EXC_VEC;
        pend_next = 1'b0;
        ras_flush = 1'b1;
      end
      SRC_HOLD: begin
        if (bus.redir_valid_i) begin
          pend_next     = 1'b1;
          pend_tgt_next = bus.redir_pc_i;
        end
      end
      SRC_REDIR, SRC_PEND: begin
        pend_next     = 1'b0;
        pc_next       = redir_bad ? EXC_VEC : redir_tgt;
        misalign_next = redir_bad;
      end
      SRC_RET: begin
        if (ras_empty) begin
          pc_next        = link_pc;
          underflow_next = 1'b1;
        end else begin
          pc_next = ras_top;
          ras_pop = 1'b1;
        end
      end
      default: pc_next = link_pc;
    endcase
  end

  // the link address is pushed whenever the fetch advances, whatever wins the mux
  assign ras_push = bus.call_i && (src inside {SRC_REDIR, SRC_PEND, SRC_RET, SRC_SEQ});

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      pc_reg        <= RESET_VEC;
      pend_reg      <= 1'b0;
      pend_tgt_reg  <= '0;
      misalign_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      pend_reg      <= pend_next;
      pend_tgt_reg  <= pend_tgt_next;
      misalign_reg  <= misalign_next;
      underflow_reg <= underflow_next;
    end
  end

  pc_ras #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (ras_push),
    .pop       (ras_pop),
    .flush     (ras_flush),
    .push_data (link_pc),
    .top       (ras_top),
    .cnt       (ras_cnt),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  a_ras_sane: assert property (@(negedge clk_i) disable iff (rst_i) !(ras_full && ras_empty));

  assign bus.pc_o            = pc_reg;
  assign bus.pend_o          = pend_reg;
  assign bus.misalign_o      = misalign_reg;
  assign bus.ras_underflow_o = underflow_reg;
  assign bus.ras_cnt_o       = ras_cnt;

endmodule
